decode_unit: RTL and testbench

//  Instruction decode stage: sits between fetch and execute_unit. Decodes one 32-bit instruction per cycle,

---
 rtl/decode_unit_pkg.sv | 44 ++++
 rtl/decode_unit_if.sv | 39 +++
 rtl/decode_unit_register_file.sv | 38 +++
 rtl/decode_unit.sv | 152 +++++++++++++++
 tb/tb_decode_unit.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_unit_pkg.sv
// Shared decode definitions: opcode/ALU codes, instruction field layout and the ID/EX bundle.
package decode_unit_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;

  localparam logic [3:0] OPC_RALU   = 4'd0;
  localparam logic [3:0] OPC_IALU   = 4'd1;
  localparam logic [3:0] OPC_LOAD   = 4'd2;
  localparam logic [3:0] OPC_STORE  = 4'd3;
  localparam logic [3:0] OPC_BRANCH = 4'd4;

  localparam logic [3:0] ALU_ADD    = 4'd0;

  typedef struct packed {
    logic [3:0]        opc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [3:0]        funct;
    logic [11:0]       imm12;
  } instr_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              valid;
    logic [3:0]        alu_op;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm_val;
    logic              use_imm;
    logic              mem_read;
    logic              mem_write;
    logic              branch_op;
    logic              reg_write;
    logic [REG_AW-1:0] rd_addr;
  } idex_t;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_unit_if.sv
// Fetch, writeback and ID/EX signal bundle between the decode stage and its neighbours.
interface decode_unit_if;
  import decode_unit_pkg::*;

  logic [XLEN-1:0]   if_pc;
  logic [XLEN-1:0]   if_instr;
  logic              if_valid;
  logic              hazard_stall;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [XLEN-1:0]   wb_data;
  logic              wb_reg_write;

  logic [XLEN-1:0]   pc_out;
  logic              valid_out;
  logic [3:0]        alu_op;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm_val;
  logic              use_imm;
  logic              mem_read;
  logic              mem_write;
  logic              branch_op;
  logic              reg_write;
  logic [REG_AW-1:0] rd_addr;
  logic              illegal_instr;

  modport master (
    output if_pc, if_instr, if_valid, wb_rd_addr, wb_data, wb_reg_write,
    input  hazard_stall, pc_out, valid_out, alu_op, rs1_data, rs2_data, imm_val,
           use_imm, mem_read, mem_write, branch_op, reg_write, rd_addr, illegal_instr
  );

  modport slave (
    input  if_pc, if_instr, if_valid, wb_rd_addr, wb_data, wb_reg_write,
    output hazard_stall, pc_out, valid_out, alu_op, rs1_data, rs2_data, imm_val,
           use_imm, mem_read, mem_write, branch_op, reg_write, rd_addr, illegal_instr
  );

endinterface

// File: rtl/decode_unit_register_file.sv
// 16x32 register file: two async read ports, one sync write port, async clear.
// Build option WB_BYPASS_EN: a same-cycle write is forwarded to a matching read port.
module decode_unit_register_file
  import decode_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  // Writeback port; never gated by stall, flush or hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

`ifdef WB_BYPASS_EN
  assign rs1_data_o = (we_i && (wr_addr_i == rs1_addr_i)) ? wr_data_i : regs_q[rs1_addr_i];
  assign rs2_data_o = (we_i && (wr_addr_i == rs2_addr_i)) ? wr_data_i : regs_q[rs2_addr_i];
`else
  assign rs1_data_o = regs_q[rs1_addr_i];
  assign rs2_data_o = regs_q[rs2_addr_i];
`endif

endmodule

// File: rtl/decode_unit.sv
// Instruction decode stage: decoder, RAW hazard check and registered ID/EX boundary.
// Build option WB_BYPASS_EN: writeback bypasses the register file, so writeback never stalls.
module decode_unit
  import decode_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_i,
  input  logic         flush_i,
  decode_unit_if.slave dbus
);

  instr_t          instr_s;
  idex_t           dec_s;
  idex_t           idex_d, idex_q;
  logic            ill_d, ill_q;
  logic            legal_s, reads_rs1_s, reads_rs2_s;
  logic            h1_rs1_s, h1_rs2_s, h2_rs1_s, h2_rs2_s, hazard_s;
  logic [XLEN-1:0] rs1_data_s, rs2_data_s;

  assign instr_s = dbus.if_instr;

  decode_unit_register_file u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr_i (instr_s.rs1),
    .rs2_addr_i (instr_s.rs2),
    .rs1_data_o (rs1_data_s),
    .rs2_data_o (rs2_data_s),
    .we_i       (dbus.wb_reg_write),
    .wr_addr_i  (dbus.wb_rd_addr),
    .wr_data_i  (dbus.wb_data)
  );

  // Opcode decode into the ID/EX bundle plus the operand-usage flags for hazard checking.
  always_comb begin
    dec_s          = '0;
    legal_s        = 1'b0;
    reads_rs1_s    = 1'b0;
    reads_rs2_s    = 1'b0;
    dec_s.pc       = dbus.if_pc;
    dec_s.valid    = 1'b1;
    dec_s.rs1_data = rs1_data_s;
    dec_s.rs2_data = rs2_data_s;
    dec_s.imm_val  = sext12(instr_s.imm12);
    dec_s.rd_addr  = instr_s.rd;
    case (instr_s.opc)
      OPC_RALU: begin
        legal_s         = 1'b1;
        reads_rs1_s     = 1'b1;
        reads_rs2_s     = 1'b1;
        dec_s.alu_op    = instr_s.funct;
        dec_s.reg_write = 1'b1;
      end
      OPC_IALU: begin
        legal_s         = 1'b1;
        reads_rs1_s     = 1'b1;
        dec_s.alu_op    = instr_s.funct;
        dec_s.use_imm   = 1'b1;
        dec_s.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        legal_s         = 1'b1;
        reads_rs1_s     = 1'b1;
        dec_s.alu_op    = ALU_ADD;
        dec_s.use_imm   = 1'b1;
        dec_s.mem_read  = 1'b1;
        dec_s.reg_write = 1'b1;
      end
      OPC_STORE: begin
        legal_s         = 1'b1;
        reads_rs1_s     = 1'b1;
        reads_rs2_s     = 1'b1;
        dec_s.alu_op    = ALU_ADD;
        dec_s.use_imm   = 1'b1;
        dec_s.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        legal_s         = 1'b1;
        reads_rs1_s     = 1'b1;
        reads_rs2_s     = 1'b1;
        dec_s.alu_op    = {1'b0, instr_s.funct[2:0]};
        dec_s.branch_op = 1'b1;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // The ID/EX producer's result is not yet on the writeback port, so it always stalls.
  assign h1_rs1_s = idex_q.valid & idex_q.reg_write & (idex_q.rd_addr == instr_s.rs1);
  assign h1_rs2_s = idex_q.valid & idex_q.reg_write & (idex_q.rd_addr == instr_s.rs2);
`ifdef WB_BYPASS_EN
  assign h2_rs1_s = 1'b0;
  assign h2_rs2_s = 1'b0;
`else
  assign h2_rs1_s = dbus.wb_reg_write & (dbus.wb_rd_addr == instr_s.rs1);
  assign h2_rs2_s = dbus.wb_reg_write & (dbus.wb_rd_addr == instr_s.rs2);
`endif
  assign hazard_s = dbus.if_valid & ((reads_rs1_s & (h1_rs1_s | h2_rs1_s)) |
                                     (reads_rs2_s & (h1_rs2_s | h2_rs2_s)));
  assign dbus.hazard_stall = hazard_s;

  // ID/EX next state: flush > stall > hazard bubble > normal decode.
  always_comb begin
    idex_d = idex_q;
    ill_d  = 1'b0;
    if (flush_i) begin
      idex_d.valid     = 1'b0;
      idex_d.reg_write = 1'b0;
      idex_d.mem_read  = 1'b0;
      idex_d.mem_write = 1'b0;
      idex_d.branch_op = 1'b0;
    end else if (stall_i) begin
      idex_d = idex_q;
    end else if (hazard_s) begin
      idex_d = '0;
    end else if (dbus.if_valid && legal_s) begin
      idex_d = dec_s;
    end else begin
      idex_d = '0;
      ill_d  = dbus.if_valid;
    end
  end

  // ID/EX boundary register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      idex_q <= idex_d;
      ill_q  <= ill_d;
    end
  end

  assign dbus.pc_out        = idex_q.pc;
  assign dbus.valid_out     = idex_q.valid;
  assign dbus.alu_op        = idex_q.alu_op;
  assign dbus.rs1_data      = idex_q.rs1_data;
  assign dbus.rs2_data      = idex_q.rs2_data;
  assign dbus.imm_val       = idex_q.imm_val;
  assign dbus.use_imm       = idex_q.use_imm;
  assign dbus.mem_read      = idex_q.mem_read;
  assign dbus.mem_write     = idex_q.mem_write;
  assign dbus.branch_op     = idex_q.branch_op;
  assign dbus.reg_write     = idex_q.reg_write;
  assign dbus.rd_addr       = idex_q.rd_addr;
  assign dbus.illegal_instr = ill_q;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: directed scenarios plus randomized traffic against a
// behavioural model of the decode rules, register file and hazard policy.
module tb_decode_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  logic flush;

  always #5 clk = ~clk;

  decode_unit_if bus ();

  decode_unit u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall_i (stall),
    .flush_i (flush),
    .dbus    (bus)
  );

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [3:0]  alu;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        mr;
    logic        mw;
    logic        br;
    logic        rw;
    logic [3:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        exp_q;
  logic [31:0] rf [16];
  int          total = 0;
  int          bad   = 0;

  function automatic exp_t observe();
    exp_t o;
    o.pc = bus.pc_out;     o.valid = bus.valid_out; o.alu = bus.alu_op;
    o.rs1 = bus.rs1_data;  o.rs2 = bus.rs2_data;    o.imm = bus.imm_val;
    o.use_imm = bus.use_imm; o.mr = bus.mem_read;   o.mw = bus.mem_write;
    o.br = bus.branch_op;  o.rw = bus.reg_write;    o.rd = bus.rd_addr;
    o.ill = bus.illegal_instr;
    return o;
  endfunction

  // Spec table: what execute should see for a legal opcode.
  function automatic exp_t model_decode(input logic [31:0] pc, input logic [31:0] ins,
                                        input logic [31:0] d1, input logic [31:0] d2);
    exp_t        e;
    logic [3:0]  op;
    e = '0;
    op = ins[31:28];
    e.pc = pc; e.valid = 1'b1; e.rs1 = d1; e.rs2 = d2; e.rd = ins[27:24];
    e.imm = {{20{ins[11]}}, ins[11:0]};
    if (op == 4'd0) begin
      e.alu = ins[15:12]; e.rw = 1'b1;
    end else if (op == 4'd1) begin
      e.alu = ins[15:12]; e.use_imm = 1'b1; e.rw = 1'b1;
    end else if (op == 4'd2) begin
      e.alu = 4'd0; e.use_imm = 1'b1; e.mr = 1'b1; e.rw = 1'b1;
    end else if (op == 4'd3) begin
      e.alu = 4'd0; e.use_imm = 1'b1; e.mw = 1'b1;
    end else begin
      e.alu = {1'b0, ins[14:12]}; e.br = 1'b1;
    end
    return e;
  endfunction

  function automatic bit dep(input logic [3:0] s, input logic wv, input logic [3:0] wa);
    return (exp_q.valid && exp_q.rw && exp_q.rd == s) || (!BYPASS && wv && wa == s);
  endfunction

  // Drives one cycle from posedge+1; returns observed and modelled hazard_stall, advances model.
  task automatic drive_cycle(input logic st, input logic fl, input logic iv,
                             input logic [31:0] pc, input logic [31:0] ins,
                             input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                             output logic haz_o, output logic haz_e);
    exp_t        nxt;
    logic [31:0] d1, d2;
    logic [3:0]  op, s1, s2;
    logic        r1, r2, hz;
    stall = st; flush = fl; bus.if_valid = iv; bus.if_pc = pc; bus.if_instr = ins;
    bus.wb_reg_write = wv; bus.wb_rd_addr = wa; bus.wb_data = wd;
    #1;
    haz_o = bus.hazard_stall;
    op = ins[31:28]; s1 = ins[23:20]; s2 = ins[19:16];
    d1 = (BYPASS && wv && wa == s1) ? wd : rf[s1];
    d2 = (BYPASS && wv && wa == s2) ? wd : rf[s2];
    r1 = (op <= 4'd4);
    r2 = (op == 4'd0) || (op == 4'd3) || (op == 4'd4);
    hz = iv && ((r1 && dep(s1, wv, wa)) || (r2 && dep(s2, wv, wa)));
    if (fl) begin
      nxt = exp_q; nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0;
      nxt.br = 1'b0; nxt.ill = 1'b0;
    end else if (st) begin
      nxt = exp_q; nxt.ill = 1'b0;
    end else if (hz || !iv) begin
      nxt = '0;
    end else if (op > 4'd4) begin
      nxt = '0; nxt.ill = 1'b1;
    end else begin
      nxt = model_decode(pc, ins, d1, d2);
    end
    @(posedge clk);
    #1;
    exp_q = nxt;
    if (wv) rf[wa] = wd;
    haz_e = hz;
  endtask

  task automatic idle();
    logic ho, he;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, ho, he);
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0;
    bus.wb_reg_write = 1'b0; bus.wb_rd_addr = '0; bus.wb_data = '0;
    exp_q = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    o = observe();
    total++; if (o !== exp_t'(0)) begin bad++; $display("FAIL reset_outputs got=%h want=0", o); end
    total++; if (bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b want=0", bus.hazard_stall); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    o = observe();
    total++; if (o !== exp_q) begin bad++; $display("FAIL post_reset_idle got=%h want=%h", o, exp_q); end
  endtask

  task automatic test_ialu();
    exp_t o;
    logic ho, he;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd2, 32'd7, ho, he);
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h100, 32'h1120_0005, 1'b0, 4'd0, 32'h0, ho, he);
    o = observe();
    total++; if (ho !== 1'b0) begin bad++; $display("FAIL ialu_hazard got=%b want=0", ho); end
    total++;
    if ({o.valid, o.alu, o.rs1, o.imm, o.use_imm, o.rd} !== {1'b1, 4'd0, 32'd7, 32'd5, 1'b1, 4'd1}) begin
      bad++; $display("FAIL ialu_fields got v=%b alu=%h rs1=%h imm=%h ui=%b rd=%h want 1 0 7 5 1 1",
                      o.valid, o.alu, o.rs1, o.imm, o.use_imm, o.rd);
    end
    total++; if (o !== exp_q) begin bad++; $display("FAIL ialu_model got=%h want=%h", o, exp_q); end
  endtask

  task automatic test_load_imm();
    exp_t o;
    logic ho, he;
    idle();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h104, 32'h2310_0FFC, 1'b0, 4'd0, 32'h0, ho, he);
    o = observe();
    total++;
    if ({o.valid, o.imm, o.mr, o.alu, o.rw} !== {1'b1, 32'hFFFF_FFFC, 1'b1, 4'd0, 1'b1}) begin
      bad++; $display("FAIL load_imm got v=%b imm=%h mr=%b alu=%h rw=%b want 1 fffffffc 1 0 1",
                      o.valid, o.imm, o.mr, o.alu, o.rw);
    end
    total++; if (o !== exp_q) begin bad++; $display("FAIL load_model got=%h want=%h", o, exp_q); end
  endtask

  task automatic test_back_to_back();
    exp_t o;
    logic ho, he;
    int   stalls;
    bit   issued;
    stalls = 0; issued = 1'b0;
    idle();
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd4, 32'h10, ho, he);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd5, 32'h20, ho, he);
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h200, 32'h0145_0000, 1'b0, 4'd0, 32'h0, ho, he);
    for (int i = 0; i < 6 && !issued; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h204, 32'h0312_1000, (i == 1), 4'd1, 32'h30, ho, he);
      total++; if (ho !== he) begin bad++; $display("FAIL b2b_hazard cycle=%0d got=%b want=%b", i, ho, he); end
      if (ho) stalls++; else issued = 1'b1;
    end
    total++; if (!issued) begin bad++; $display("FAIL b2b_issue got=none want=issued within 6 cycles"); end
    total++;
    if (stalls != (BYPASS ? 1 : 2)) begin
      bad++; $display("FAIL b2b_bubbles got=%0d want=%0d", stalls, BYPASS ? 1 : 2);
    end
    o = observe();
    total++;
    if ({o.valid, o.alu, o.rd, o.rs1, o.rs2} !== {1'b1, 4'd1, 4'd3, 32'h30, 32'd7}) begin
      bad++; $display("FAIL b2b_sub got v=%b alu=%h rd=%h rs1=%h rs2=%h want 1 1 3 30 7",
                      o.valid, o.alu, o.rd, o.rs1, o.rs2);
    end
  endtask

  task automatic test_flush_stall();
    exp_t o, held;
    logic ho, he;
    idle();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h300, 32'h0678_0000, 1'b0, 4'd0, 32'h0, ho, he);
    total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%b want=1", bus.valid_out); end
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h304, 32'h0A12_0000, 1'b0, 4'd0, 32'h0, ho, he);
    o = observe();
    total++;
    if ({o.valid, o.rw, o.mr, o.mw, o.br} !== 5'b00000) begin
      bad++; $display("FAIL flush_stall got v=%b rw=%b mr=%b mw=%b br=%b want all 0", o.valid, o.rw, o.mr, o.mw, o.br);
    end
    total++; if (o !== exp_q) begin bad++; $display("FAIL flush_model got=%h want=%h", o, exp_q); end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h308, 32'h0B12_0000, 1'b0, 4'd0, 32'h0, ho, he);
    held = observe();
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h30C, 32'h1C34_0001, 1'b0, 4'd0, 32'h0, ho, he);
    o = observe();
    total++;
    if ({o.valid, o.rd, o.pc} !== {1'b1, 4'hB, 32'h308} || o !== held) begin
      bad++; $display("FAIL stall_hold got=%h want=%h", o, held);
    end
  endtask

  task automatic test_illegal();
    exp_t o;
    logic ho, he;
    idle();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h400, 32'h7123_4567, 1'b0, 4'd0, 32'h0, ho, he);
    o = observe();
    total++; if ({o.ill, o.valid} !== 2'b10) begin bad++; $display("FAIL illegal_pulse got ill=%b v=%b want 1 0", o.ill, o.valid); end
    idle();
    total++; if (bus.illegal_instr !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b want=0", bus.illegal_instr); end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h404, 32'hF000_0000, 1'b0, 4'd0, 32'h0, ho, he);
    total++; if (bus.illegal_instr !== 1'b0) begin bad++; $display("FAIL illegal_invalid got=%b want=0", bus.illegal_instr); end
  endtask

  task automatic test_store_no_h1();
    exp_t o;
    logic ho, he;
    idle();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h500, 32'h3512_0004, 1'b0, 4'd0, 32'h0, ho, he);
    o = observe();
    total++; if ({o.mw, o.rw, o.use_imm} !== 3'b101) begin bad++; $display("FAIL store_ctrl got mw=%b rw=%b ui=%b want 1 0 1", o.mw, o.rw, o.use_imm); end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h504, 32'h0957_0000, 1'b0, 4'd0, 32'h0, ho, he);
    total++; if (ho !== 1'b0) begin bad++; $display("FAIL store_h1 got=%b want=0", ho); end
    total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL store_next_issue got=%b want=1", bus.valid_out); end
  endtask

  task automatic test_random();
    exp_t        o;
    logic        ho, he;
    logic [31:0] ins;
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[31:28] = 4'($urandom_range(0, 7));
      drive_cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
                  $urandom, ins, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), $urandom, ho, he);
      total++; if (ho !== he) begin bad++; $display("FAIL rand_hazard n=%0d got=%b want=%b", n, ho, he); end
      o = observe();
      total++; if (o !== exp_q) begin bad++; $display("FAIL rand_outputs n=%0d got=%h want=%h", n, o, exp_q); end
    end
  endtask

  task automatic test_reset_midrun();
    exp_t        o;
    logic        ho, he;
    logic [3:0]  r4;
    for (int r = 1; r < 16; r++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'(r), 32'h100 + 32'(r), ho, he);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h600, 32'h0123_0000, 1'b0, 4'd0, 32'h0, ho, he);
    total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b want=1", bus.valid_out); end
    rst_n = 1'b0; bus.if_valid = 1'b0; bus.wb_reg_write = 1'b0;
    #1;
    o = observe();
    total++; if (o !== exp_t'(0)) begin bad++; $display("FAIL midrst_outputs got=%h want=0", o); end
    exp_q = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 1; r < 16; r++) begin
      r4 = 4'(r);
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h700, {8'h00, r4, r4, 16'h0000}, 1'b0, 4'd0, 32'h0, ho, he);
      o = observe();
      total++;
      if ({o.valid, o.rs1, o.rs2} !== {1'b1, 32'h0, 32'h0}) begin
        bad++; $display("FAIL midrst_reg r%0d got v=%b rs1=%h rs2=%h want 1 0 0", r, o.valid, o.rs1, o.rs2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ialu();
    test_load_imm();
    test_back_to_back();
    test_flush_stall();
    test_illegal();
    test_store_no_h1();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
